// File: rtl/pattern_scan_pkg.sv
// Shared types and sizing helpers for the sequential pattern scan engine.
// Also imported by the bench so both sides derive the same widths.
package pattern_scan_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } scan_state_t;

  function automatic int npos(input int text_w, input int pat_w);
    return text_w - pat_w + 1;
  endfunction

  function automatic int pos_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pattern_window_cmp.sv
// Masked compare of one pattern-wide text window; a cleared mask bit is a don't-care.
module pattern_window_cmp #(
  parameter int PAT_W = 4
) (
  input  logic [PAT_W-1:0] i_window,
  input  logic [PAT_W-1:0] i_pat,
  input  logic [PAT_W-1:0] i_mask,
  output logic             o_hit
);

  assign o_hit = (((i_window ^ i_pat) & i_mask) == '0);

endmodule

// File: rtl/pattern_scan_engine.sv
// Handshaked pattern scanner: accepts one job, evaluates one alignment per cycle,
// then holds the result until the consumer takes it.
module pattern_scan_engine
  import pattern_scan_pkg::*;
#(
  parameter int TEXT_W = 8,
  parameter int PAT_W  = 4,
  localparam int NPOS  = npos(TEXT_W, PAT_W),
  localparam int POS_W = pos_w(NPOS),
  localparam int CNT_W = $clog2(NPOS + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [TEXT_W-1:0] in_text,
  input  logic [PAT_W-1:0]  in_pat,
  input  logic [PAT_W-1:0]  in_mask,
  input  logic              in_mode,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [NPOS-1:0]   out_hits,
  output logic              out_any,
  output logic [POS_W-1:0]  out_first,
  output logic [CNT_W-1:0]  out_count
);

  localparam logic [POS_W-1:0] LAST_POS = POS_W'(NPOS - 1);

  scan_state_t       r_state;
  logic [POS_W-1:0]  r_idx;
  logic [TEXT_W-1:0] r_text;
  logic [PAT_W-1:0]  r_pat;
  logic [PAT_W-1:0]  r_mask;
  logic              r_mode;
  logic              r_in_ready;
  logic              r_out_valid;
  logic [NPOS-1:0]   r_hits;
  logic [POS_W-1:0]  r_first;
  logic [CNT_W-1:0]  r_count;

  logic [NPOS-1:0]   w_pos_hit;
  logic              w_cur_hit;

  // One comparator per alignment; the FSM picks the one selected by idx.
  generate
    for (genvar gi = 0; gi < NPOS; gi++) begin : g_cmp
      pattern_window_cmp #(.PAT_W(PAT_W)) u_cmp (
        .i_window (r_text[gi +: PAT_W]),
        .i_pat    (r_pat),
        .i_mask   (r_mask),
        .o_hit    (w_pos_hit[gi])
      );
    end
  endgenerate

  assign w_cur_hit = w_pos_hit[r_idx];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_idx       <= '0;
      r_text      <= '0;
      r_pat       <= '0;
      r_mask      <= '0;
      r_mode      <= 1'b0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_hits      <= '0;
      r_first     <= '0;
      r_count     <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_text     <= in_text;
            r_pat      <= in_pat;
            r_mask     <= in_mask;
            r_mode     <= in_mode;
            r_hits     <= '0;
            r_first    <= '0;
            r_count    <= '0;
            r_idx      <= '0;
            r_in_ready <= 1'b0;
            r_state    <= SCAN;
          end
        end
        SCAN: begin
          if (w_cur_hit) begin
            r_hits[r_idx] <= 1'b1;
            // A zero count means nothing has hit yet, so this is the lowest position.
            if (r_count == '0) begin
              r_first <= r_idx;
            end
            r_count <= r_count + CNT_W'(1);
          end
          if ((r_idx == LAST_POS) || (r_mode && w_cur_hit)) begin
            r_out_valid <= 1'b1;
            r_state     <= DONE;
          end else begin
            r_idx <= r_idx + POS_W'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= IDLE;
          end
        end
        default: begin
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
          r_state     <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_hits  = r_hits;
  assign out_first = r_first;
  assign out_count = r_count;
  assign out_any   = (r_count != '0);

endmodule

// File: tb/tb_pattern_scan_engine.sv
// Directed bench for pattern_scan_engine: vector table plus backpressure,
// mid-scan reset and reset-versus-valid sequences.
module tb_pattern_scan_engine;
  import pattern_scan_pkg::*;

  localparam int TEXT_W = 8;
  localparam int PAT_W  = 4;
  localparam int NPOS   = npos(TEXT_W, PAT_W);
  localparam int POS_W  = pos_w(NPOS);
  localparam int CNT_W  = $clog2(NPOS + 1);
  localparam int MAX_WAIT = 50;

  typedef struct {
    logic [TEXT_W-1:0] text;
    logic [PAT_W-1:0]  pat;
    logic [PAT_W-1:0]  mask;
    logic              mode;
    logic [NPOS-1:0]   hits;
    int                first;
    int                count;
    int                lat;
  } vec_t;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [TEXT_W-1:0] in_text;
  logic [PAT_W-1:0]  in_pat;
  logic [PAT_W-1:0]  in_mask;
  logic              in_mode;
  logic              out_valid;
  logic              out_ready;
  logic [NPOS-1:0]   out_hits;
  logic              out_any;
  logic [POS_W-1:0]  out_first;
  logic [CNT_W-1:0]  out_count;

  int checks = 0;
  int errors = 0;

  vec_t vecs[10];

  always #5 clk = ~clk;

  pattern_scan_engine #(.TEXT_W(TEXT_W), .PAT_W(PAT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_text   (in_text),
    .in_pat    (in_pat),
    .in_mask   (in_mask),
    .in_mode   (in_mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_hits  (out_hits),
    .out_any   (out_any),
    .out_first (out_first),
    .out_count (out_count)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_idle_zero(input string tag);
    chk({tag, " in_ready"},  int'(in_ready), 1);
    chk({tag, " out_valid"}, int'(out_valid), 0);
    chk({tag, " hits"},      int'(out_hits), 0);
    chk({tag, " any"},       int'(out_any), 0);
    chk({tag, " first"},     int'(out_first), 0);
    chk({tag, " count"},     int'(out_count), 0);
  endtask

  // Offer a job and let it be accepted on the next rising edge (E0).
  task automatic start_job(input vec_t v, input string tag);
    @(negedge clk);
    in_text  = v.text;
    in_pat   = v.pat;
    in_mask  = v.mask;
    in_mode  = v.mode;
    in_valid = 1'b1;
    chk({tag, " in_ready@offer"}, int'(in_ready), 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Count edges after E0 until out_valid appears, bounded.
  task automatic wait_result(output int lat);
    lat = 0;
    while (!out_valid && lat < MAX_WAIT) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic check_result(input vec_t v, input string tag, input int lat);
    chk({tag, " out_valid"}, int'(out_valid), 1);
    chk({tag, " latency"},   lat, v.lat);
    chk({tag, " hits"},      int'(out_hits), int'(v.hits));
    chk({tag, " any"},       int'(out_any), (v.count != 0) ? 1 : 0);
    chk({tag, " first"},     int'(out_first), v.first);
    chk({tag, " count"},     int'(out_count), v.count);
    chk({tag, " in_ready"},  int'(in_ready), 0);
    $display("job %s: text=%b pat=%b mask=%b mode=%0d -> hits=%b first=%0d count=%0d lat=%0d",
             tag, v.text, v.pat, v.mask, v.mode, out_hits, out_first, out_count, lat);
  endtask

  task automatic consume(input string tag);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk({tag, " in_ready after take"},  int'(in_ready), 1);
    chk({tag, " out_valid after take"}, int'(out_valid), 0);
  endtask

  task automatic run_job(input vec_t v, input string tag);
    int lat;
    start_job(v, tag);
    wait_result(lat);
    check_result(v, tag, lat);
    consume(tag);
  endtask

  initial begin
    int lat;
    logic [NPOS-1:0]  held_hits;
    logic [POS_W-1:0] held_first;
    logic [CNT_W-1:0] held_count;

    //          text          pat      mask     md  hits      first cnt lat
    vecs[0] = '{8'b11100011, 4'b1110, 4'b1111, 1'b0, 5'b10000, 4, 1, 5};
    vecs[1] = '{8'b10111011, 4'b1010, 4'b1111, 1'b0, 5'b00000, 0, 0, 5};
    vecs[2] = '{8'b11101011, 4'b1010, 4'b1111, 1'b0, 5'b00100, 2, 1, 5};
    vecs[3] = '{8'b11101011, 4'b1010, 4'b1111, 1'b1, 5'b00100, 2, 1, 3};
    vecs[4] = '{8'b11100011, 4'b1110, 4'b0000, 1'b0, 5'b11111, 0, 5, 5};
    vecs[5] = '{8'b11100011, 4'b1110, 4'b0000, 1'b1, 5'b00001, 0, 1, 1};
    vecs[6] = '{8'b10101010, 4'b1010, 4'b1111, 1'b0, 5'b10101, 0, 3, 5};
    vecs[7] = '{8'b10101010, 4'b1010, 4'b1111, 1'b1, 5'b00001, 0, 1, 1};
    vecs[8] = '{8'b11100011, 4'b0000, 4'b0100, 1'b0, 5'b00111, 0, 3, 5};
    vecs[9] = '{8'b11100011, 4'b1110, 4'b1111, 1'b1, 5'b10000, 4, 1, 5};

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_text   = '0;
    in_pat    = '0;
    in_mask   = '0;
    in_mode   = 1'b0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_idle_zero("reset");
    rst = 1'b0;

    for (int i = 0; i < 10; i++) begin
      run_job(vecs[i], $sformatf("vec%0d", i));
    end

    // Backpressure: result must hold while out_ready stays low.
    start_job(vecs[0], "bp");
    wait_result(lat);
    check_result(vecs[0], "bp", lat);
    held_hits  = out_hits;
    held_first = out_first;
    held_count = out_count;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk);
      #1;
      chk("bp hold out_valid", int'(out_valid), 1);
      chk("bp hold in_ready",  int'(in_ready), 0);
      chk("bp hold hits",      int'(out_hits), int'(held_hits));
      chk("bp hold first",     int'(out_first), int'(held_first));
      chk("bp hold count",     int'(out_count), int'(held_count));
    end
    consume("bp");
    run_job(vecs[3], "bp next");

    // Reset while scanning at idx 2, with one hit already recorded.
    start_job(vecs[6], "midrst");
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_idle_zero("midrst");
    @(posedge clk);
    #1;
    chk("midrst no result", int'(out_valid), 0);
    run_job(vecs[2], "after rst");

    // Reset and in_valid together: job must not be taken.
    @(negedge clk);
    rst      = 1'b1;
    in_valid = 1'b1;
    in_text  = vecs[0].text;
    in_pat   = vecs[0].pat;
    in_mask  = vecs[0].mask;
    in_mode  = 1'b0;
    @(posedge clk);
    #1;
    rst      = 1'b0;
    in_valid = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    chk("rst+valid in_ready",  int'(in_ready), 1);
    chk("rst+valid out_valid", int'(out_valid), 0);
    run_job(vecs[1], "after rst+valid");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pattern_scan_engine.md
# pattern_scan_engine

Parametrised, handshaked successor to the team's combinational 8-bit/4-bit pattern matcher. It accepts a text word, a pattern and a compare mask in one transfer, then scans every alignment sequentially, one position per cycle. It returns a per-position hit vector, an any-hit flag, the lowest hit position and a hit count. It sits between a text/pattern producer and a result consumer, using valid/ready on both sides.

## Interface
Parameters:
- TEXT_W, 8: text width in bits; must be ≥ PAT_W.
- PAT_W, 4: pattern width in bits; must be ≥ 1.
- NPOS (derived), TEXT_W-PAT_W+1: number of alignments.
- POS_W (derived), max(1, clog2(NPOS)): position index width.
- CNT_W (derived), clog2(NPOS+1): hit count width.

Ports:
- clk  in  1  single clock; all logic on its rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  job offered.
- in_ready  out  1  engine can accept a job.
- in_text  in  TEXT_W  text word.
- in_pat  in  PAT_W  pattern.
- in_mask  in  PAT_W  1 = compare this bit; 0 = don't care.
- in_mode  in  1  0 = scan all positions; 1 = stop at first hit.
- out_valid  out  1  result available.
- out_ready  in  1  consumer takes the result.
- out_hits  out  NPOS  bit p set when position p matches.
- out_any  out  1  OR of out_hits.
- out_first  out  POS_W  lowest hit position; 0 when there is no hit.
- out_count  out  CNT_W  number of set bits in out_hits.

## Operation
- Position p compares in_text[p+PAT_W-1:p] against in_pat.
- Position p matches when ((window ^ pat) & mask) == 0.
- FSM states: IDLE, SCAN, DONE.
- IDLE: in_ready=1 and out_valid=0.
  - On in_valid&&in_ready: latch text, pat, mask and mode; clear hits, count and first; set idx=0; go to SCAN.
- SCAN: in_ready=0. Each cycle evaluates position idx.
  - On a hit: set hits[idx]. If this is the first hit, load first=idx. Increment count.
  - Exit to DONE when idx==NPOS-1.
  - Also exit to DONE when mode=1 and the current position hits.
  - Otherwise idx increments.
- DONE: out_valid=1 and outputs are held stable.
  - On out_valid&&out_ready: go to IDLE.
  - in_ready stays 0 in DONE, so no job is accepted in the handshake cycle.
- A mask of all zeros makes every scanned position hit.
- Mode 1 with no hit scans all NPOS positions, identical to mode 0.
- out_any is derived from the registered count (count≠0).
- out_count never exceeds NPOS, so it never saturates.
- Reset value of every output:
  - in_ready=1.
  - out_valid=0.
  - out_hits, out_any, out_first, out_count = 0.
  - Internal state: IDLE, idx=0.

## Timing
- Accept on edge E0.
  - Mode 0: the scan edges are E1..E_NPOS; out_valid is high after edge E_NPOS.
  - Mode 1 with first hit at position h: out_valid is high after edge E(h+1).
- With default parameters, latency is 5 cycles in mode 0 and h+1 cycles in mode 1.
- Result is consumed on edge Ec; in_ready=1 after Ec.
  - Minimum job period is therefore latency + 2 cycles.
- out_ready held low: the DONE state and all outputs are unchanged indefinitely.
- rst during any state: state is IDLE and outputs are at reset values after that edge. An in-flight job is discarded with no result.
- rst and in_valid in the same cycle: rst wins and the job is not accepted.
- Degenerate case PAT_W==TEXT_W: NPOS=1, POS_W=1, one scan cycle.

## Structure
- Package pattern_scan_pkg contains:
  - state enum {IDLE, SCAN, DONE};
  - functions npos(TEXT_W, PAT_W) and pos_w(npos), shared with the bench.
- Sub-module pattern_window_cmp (combinational) performs the masked compare of one PAT_W window against pattern and mask, returning the hit bit.
- The top level holds the FSM, the idx counter, the latched operands and the result registers.

## Test plan
All scenarios use default parameters.
1. text 8'b11100011, pat 4'b1110, mask 4'b1111, mode 0 → hits 5'b10000, any 1, first 4, count 1. out_valid rises 5 cycles after accept.
2. text 8'b10111011, pat 4'b1010, mask 4'b1111, mode 0 → hits 5'b00000, any 0, first 0, count 0.
3. text 8'b11101011, pat 4'b1010, full mask:
   - mode 0 → hits 5'b00100, first 2, count 1, latency 5.
   - mode 1 → same result with latency 3.
4. text 8'b11100011, pat 4'b1110, mask 4'b0000, mode 0 → hits 5'b11111, count 5, first 0. Repeat in mode 1 → hits 5'b00001, count 1, latency 1.
5. Backpressure: hold out_ready=0 for 4 cycles after out_valid → outputs stable and in_ready=0. Raise out_ready → in_ready=1 the next cycle; a back-to-back job is accepted and correct.
6. Assert rst in SCAN at idx 2 → next cycle in_ready=1, out_valid=0, all result outputs 0. The following job gives its correct result.
